// File: rtl/fnd_pkg.sv
// Shared encodings for the 4-digit FND scan controller: scan states,
// active-low 7-segment font codes and the all-commons-off pattern.
package fnd_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Fonts are {dp,g,f,e,d,c,b,a}, active low, with dp off
   localparam logic [7:0] FONT_0     = 8'hC0;
   localparam logic [7:0] FONT_1     = 8'hF9;
   localparam logic [7:0] FONT_2     = 8'hA4;
   localparam logic [7:0] FONT_3     = 8'hB0;
   localparam logic [7:0] FONT_4     = 8'h99;
   localparam logic [7:0] FONT_5     = 8'h92;
   localparam logic [7:0] FONT_6     = 8'h82;
   localparam logic [7:0] FONT_7     = 8'hF8;
   localparam logic [7:0] FONT_8     = 8'h80;
   localparam logic [7:0] FONT_9     = 8'h90;
   localparam logic [7:0] FONT_BLANK = 8'hFF;

   localparam logic [3:0] COM_OFF = 4'b1111;

   function automatic logic [3:0] com_select(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment font; codes 10-15 show no
// segments but still light the decimal point when requested.
module bcd_to_7seg
   import fnd_pkg::*;
(
   input  logic [3:0] i_bcd,
   input  logic       i_dp,
   output logic [7:0] o_font
);

   logic [7:0] seg;

   always_comb begin
      seg = FONT_BLANK;
      case (i_bcd)
         4'd0:    seg = FONT_0;
         4'd1:    seg = FONT_1;
         4'd2:    seg = FONT_2;
         4'd3:    seg = FONT_3;
         4'd4:    seg = FONT_4;
         4'd5:    seg = FONT_5;
         4'd6:    seg = FONT_6;
         4'd7:    seg = FONT_7;
         4'd8:    seg = FONT_8;
         4'd9:    seg = FONT_9;
         default: seg = FONT_BLANK;
      endcase
      o_font = {~i_dp, seg[6:0]};
   end

endmodule

// File: rtl/fnd_scan_controller.sv
// Time-multiplexed 4-digit common-anode FND driver with per-slot blanking
// guard, leading-zero suppression and per-digit blink.
module fnd_scan_controller
   import fnd_pkg::*;
#(
   parameter int CLK_HZ       = 100_000_000,
   parameter int SCAN_HZ      = 1000,
   parameter int GUARD        = 100,
   parameter int BLINK_FRAMES = 125
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] i_digit0,
   input  logic [3:0] i_digit1,
   input  logic [3:0] i_digit2,
   input  logic [3:0] i_digit3,
   input  logic       i_blank_lz,
   input  logic [3:0] i_blink_en,
   input  logic [3:0] i_dp,
   output logic [3:0] o_fnd_com,
   output logic [7:0] o_fnd_font,
   output logic       o_frame_tick
);

   localparam int DIV     = CLK_HZ / SCAN_HZ;
   localparam int SLOT_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(DIV - 1);
   localparam logic [SLOT_W-1:0]  GUARD_LAST = SLOT_W'(GUARD - 1);
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

   scan_state_e        state_q, state_d;
   logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
   logic [1:0]         digit_idx_q, digit_idx_d;
   logic [3:0]         hold_digit_q, hold_digit_d;
   logic               hold_blink_q, hold_blink_d;
   logic               hold_dp_q, hold_dp_d;
   logic               hold_lz_q, hold_lz_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               blink_phase_q, blink_phase_d;
   logic [3:0]         com_q, com_d;
   logic [7:0]         font_q, font_d;
   logic               tick_q, tick_d;

   logic               slot_wrap;
   logic               capture;
   logic [3:0]         cur_digit;
   logic               cur_lz;
   logic [7:0]         dec_font;

   bcd_to_7seg u_dec (
      .i_bcd  (hold_digit_q),
      .i_dp   (hold_dp_q),
      .o_font (dec_font)
   );

   // Pick the inputs for the digit being scanned; a digit is a leading zero
   // only when it and every digit to its left are zero.
   always_comb begin
      cur_digit = i_digit0;
      cur_lz    = 1'b0;
      case (digit_idx_q)
         2'd1: begin
            cur_digit = i_digit1;
            cur_lz    = (i_digit3 == 4'd0) && (i_digit2 == 4'd0) && (i_digit1 == 4'd0);
         end
         2'd2: begin
            cur_digit = i_digit2;
            cur_lz    = (i_digit3 == 4'd0) && (i_digit2 == 4'd0);
         end
         2'd3: begin
            cur_digit = i_digit3;
            cur_lz    = (i_digit3 == 4'd0);
         end
         default: ;
      endcase
   end

   always_comb begin
      slot_wrap     = (slot_cnt_q == SLOT_LAST);
      capture       = (state_q == ST_BLANK) && (slot_cnt_q == GUARD_LAST);
      slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + SLOT_W'(1);
      digit_idx_d   = slot_wrap ? digit_idx_q + 2'd1 : digit_idx_q;
      state_d       = state_q;
      hold_digit_d  = hold_digit_q;
      hold_blink_d  = hold_blink_q;
      hold_dp_d     = hold_dp_q;
      hold_lz_d     = hold_lz_q;
      if (slot_wrap) begin
         state_d = ST_BLANK;
      end else if (capture) begin
         state_d      = ST_DRIVE;
         hold_digit_d = cur_digit;
         hold_blink_d = i_blink_en[digit_idx_q];
         hold_dp_d    = i_dp[digit_idx_q];
         hold_lz_d    = i_blank_lz && cur_lz;
      end
   end

   // Output registers plus the frame-based blink phase
   always_comb begin
      com_d         = COM_OFF;
      font_d        = FONT_BLANK;
      tick_d        = slot_wrap && (digit_idx_q == 2'd3);
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      if (state_q == ST_DRIVE) begin
         com_d = com_select(digit_idx_q);
         if (!hold_lz_q && !(blink_phase_q && hold_blink_q)) begin
            font_d = dec_font;
         end
      end
      if (tick_q) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_BLANK;
         slot_cnt_q    <= '0;
         digit_idx_q   <= 2'd0;
         hold_digit_q  <= 4'd0;
         hold_blink_q  <= 1'b0;
         hold_dp_q     <= 1'b0;
         hold_lz_q     <= 1'b0;
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         com_q         <= COM_OFF;
         font_q        <= FONT_BLANK;
         tick_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         slot_cnt_q    <= slot_cnt_d;
         digit_idx_q   <= digit_idx_d;
         hold_digit_q  <= hold_digit_d;
         hold_blink_q  <= hold_blink_d;
         hold_dp_q     <= hold_dp_d;
         hold_lz_q     <= hold_lz_d;
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
         com_q         <= com_d;
         font_q        <= font_d;
         tick_q        <= tick_d;
      end
   end

   assign o_fnd_com    = com_q;
   assign o_fnd_font   = font_q;
   assign o_frame_tick = tick_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: each drive interval (common
// asserted) is popped from an expected queue and checked for value, length,
// preceding blank gap and frame tick placement.
module tb_fnd_scan_controller;

   localparam int DRIVE_LEN = 8;

   typedef struct {
      logic [3:0] com;
      logic [7:0] font;
      int         gap;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] i_digit0 = 4'd0;
   logic [3:0] i_digit1 = 4'd0;
   logic [3:0] i_digit2 = 4'd0;
   logic [3:0] i_digit3 = 4'd0;
   logic       i_blank_lz = 1'b0;
   logic [3:0] i_blink_en = 4'd0;
   logic [3:0] i_dp = 4'd0;
   logic [3:0] o_fnd_com;
   logic [7:0] o_fnd_font;
   logic       o_frame_tick;

   exp_t exp_q[$];
   int   compared = 0;
   int   mismatched = 0;
   int   push_count = 0;
   int   done_count = 0;

   fnd_scan_controller #(
      .CLK_HZ       (1000),
      .SCAN_HZ      (100),
      .GUARD        (2),
      .BLINK_FRAMES (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_digit0     (i_digit0),
      .i_digit1     (i_digit1),
      .i_digit2     (i_digit2),
      .i_digit3     (i_digit3),
      .i_blank_lz   (i_blank_lz),
      .i_blink_en   (i_blink_en),
      .i_dp         (i_dp),
      .o_fnd_com    (o_fnd_com),
      .o_fnd_font   (o_fnd_font),
      .o_frame_tick (o_frame_tick)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                                input logic [3:0] d0, input logic lz, input logic [3:0] blink,
                                input logic [3:0] dp);
      i_digit3   = d3;
      i_digit2   = d2;
      i_digit1   = d1;
      i_digit0   = d0;
      i_blank_lz = lz;
      i_blink_en = blink;
      i_dp       = dp;
   endtask

   task automatic pushExp(input logic [3:0] com, input logic [7:0] font, input int gap);
      exp_t e;
      e.com  = com;
      e.font = font;
      e.gap  = gap;
      exp_q.push_back(e);
      push_count++;
   endtask

   task automatic pushFrame(input logic [7:0] f0, input logic [7:0] f1, input logic [7:0] f2,
                            input logic [7:0] f3, input int gap0);
      pushExp(4'b1110, f0, gap0);
      pushExp(4'b1101, f1, 2);
      pushExp(4'b1011, f2, 2);
      pushExp(4'b0111, f3, 2);
   endtask

   // Called just after a rising edge; leaves the bench 1 time unit after
   // the release edge so later timing is counted from reset release.
   task automatic doReset(input int cycles);
      #1 reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      int budget = 0;
      while (done_count < push_count && budget < 2000) begin
         @(posedge clk);
         budget++;
      end
      checkOutput({tag, "_drain"}, done_count, push_count);
      if (done_count < push_count) begin
         exp_q.delete();
         done_count = push_count;
      end
   endtask

   // Monitor: runs on the falling edge, away from the active edge
   initial begin
      exp_t       cur;
      bit         in_iv = 0;
      bit         have_exp = 0;
      bit         iv_bad = 0;
      bit         gap_bad = 0;
      int         gap_len = 0;
      int         iv_len = 0;
      int         iv_ticks = 0;
      logic [11:0] bad_val = '0;
      logic [11:0] last_val = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (in_iv) begin
               in_iv = 0;
               done_count++;
            end
            gap_len = 0;
            gap_bad = 0;
         end else if (o_fnd_com != 4'b1111) begin
            if (!in_iv) begin
               in_iv    = 1;
               iv_len   = 0;
               iv_ticks = 0;
               iv_bad   = 0;
               if (exp_q.size() == 0) begin
                  have_exp = 0;
                  checkOutput("unexpected_slot_com", int'(o_fnd_com), 4'hF);
               end else begin
                  cur      = exp_q.pop_front();
                  have_exp = 1;
                  checkOutput("blank_gap_len", gap_len, cur.gap);
                  checkOutput("blank_gap_font_tick_clean", int'(gap_bad), 0);
               end
            end
            iv_len++;
            iv_ticks += int'(o_frame_tick);
            last_val = {o_fnd_com, o_fnd_font};
            if (have_exp && !iv_bad && last_val !== {cur.com, cur.font}) begin
               iv_bad  = 1;
               bad_val = last_val;
            end
         end else begin
            if (in_iv) begin
               in_iv = 0;
               if (have_exp) begin
                  checkOutput("slot_com_font", int'(iv_bad ? bad_val : last_val), int'({cur.com, cur.font}));
                  checkOutput("slot_drive_len", iv_len, DRIVE_LEN);
                  checkOutput("slot_frame_ticks", iv_ticks, (cur.com == 4'b0111) ? 1 : 0);
               end
               done_count++;
               gap_len = 0;
               gap_bad = 0;
            end
            gap_len++;
            if (o_fnd_font !== 8'hFF || o_frame_tick !== 1'b0) gap_bad = 1;
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Plain scan of digits 1,2,3,4
      applyStimulus(4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 4'b0000, 4'b0000);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 3);
      pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 2);
      waitDrain("plain_scan");

      // Leading-zero blanking
      applyStimulus(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'b0000, 4'b0000);
      doReset(1);
      pushFrame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 3);
      waitDrain("lz_all_zero");

      applyStimulus(4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 4'b0000, 4'b0000);
      doReset(1);
      pushFrame(8'hC0, 8'h92, 8'hFF, 8'hFF, 3);
      waitDrain("lz_d1_five");

      applyStimulus(4'd0, 4'd5, 4'd0, 4'd0, 1'b1, 4'b0000, 4'b0000);
      doReset(1);
      pushFrame(8'hC0, 8'hC0, 8'h92, 8'hFF, 3);
      waitDrain("lz_d2_five");

      // Blink on digit 0: two frames visible, two blank, two visible
      applyStimulus(4'd3, 4'd2, 4'd1, 4'd7, 1'b0, 4'b0001, 4'b0000);
      doReset(1);
      pushFrame(8'hF8, 8'hF9, 8'hA4, 8'hB0, 3);
      pushFrame(8'hF8, 8'hF9, 8'hA4, 8'hB0, 2);
      pushFrame(8'hFF, 8'hF9, 8'hA4, 8'hB0, 2);
      pushFrame(8'hFF, 8'hF9, 8'hA4, 8'hB0, 2);
      pushFrame(8'hF8, 8'hF9, 8'hA4, 8'hB0, 2);
      pushFrame(8'hF8, 8'hF9, 8'hA4, 8'hB0, 2);
      waitDrain("blink_d0");

      // Digit 1 changes mid-drive; dp on digit 3
      applyStimulus(4'd0, 4'd0, 4'd3, 4'd0, 1'b0, 4'b0000, 4'b1000);
      doReset(1);
      pushFrame(8'hC0, 8'hB0, 8'hC0, 8'h40, 3);
      pushFrame(8'hC0, 8'h80, 8'hC0, 8'h40, 2);
      repeat (15) @(posedge clk);
      #1 i_digit1 = 4'd8;
      waitDrain("mid_slot_change");

      // Non-BCD code with and without decimal point
      applyStimulus(4'd0, 4'hC, 4'd0, 4'd0, 1'b0, 4'b0000, 4'b0100);
      doReset(1);
      pushFrame(8'hC0, 8'hC0, 8'h7F, 8'hC0, 3);
      waitDrain("code_c_dp");

      applyStimulus(4'd0, 4'hC, 4'd0, 4'd0, 1'b0, 4'b0000, 4'b0000);
      doReset(1);
      pushFrame(8'hC0, 8'hC0, 8'hFF, 8'hC0, 3);
      waitDrain("code_c_nodp");

      // Reset pulse during the digit-2 drive interval
      applyStimulus(4'd4, 4'd3, 4'd2, 4'd1, 1'b0, 4'b0000, 4'b0000);
      doReset(1);
      pushExp(4'b1110, 8'hF9, 3);
      pushExp(4'b1101, 8'hA4, 2);
      pushExp(4'b1011, 8'hB0, 2);
      pushFrame(8'hF9, 8'hA4, 8'hB0, 8'h99, 3);
      repeat (25) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      waitDrain("reset_mid_drive");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
